mem_port_arbiter: RTL and testbench

//   Shares the single BRAM/SPRAM access port between two requesters: r0 = UART host controller, r1 = fabric client.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 29 ++
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester ids and grant helper for mem_port_arbiter
// Exports: state_t (IDLE, OWN), REQ_HOST, REQ_FABRIC, onehot() requester-to-grant conversion.
package mem_arb_pkg;
    typedef enum logic {IDLE, OWN} state_t;
    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_FABRIC = 1'b1;
    function automatic logic [1:0] onehot(input logic r);
        return (r == REQ_FABRIC) ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side bus of the memory port arbiter
// Requester side: req, lock, wr, spram, sel, addr, wdata (r0 in low slices); gnt, rvalid, rdata back.
// Memory side: mem_out in; mem_select, mem_addr, sp_addr, write_data, rd_en, wr_en, bram_or_spram out.
// timeout exists only when MEM_ARB_TIMEOUT_EN is defined.
// slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
    parameter int MEM_SELECT_BITS = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [1:0] req, lock, wr, spram, gnt, rvalid;
    logic [2*MEM_SELECT_BITS-1:0] sel;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata, mem_out, write_data;
    logic [MEM_SELECT_BITS-1:0] mem_select;
    logic [7:0] mem_addr;
    logic [13:0] sp_addr;
    logic rd_en, wr_en, bram_or_spram;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [1:0] timeout;
`endif
    modport slave (
        input req, lock, wr, spram, sel, addr, wdata, mem_out,
        output gnt, rvalid, rdata, mem_select, mem_addr, sp_addr, write_data, rd_en, wr_en, bram_or_spram
`ifdef MEM_ARB_TIMEOUT_EN
        , output timeout
`endif
    );
    modport master (
        output req, lock, wr, spram, sel, addr, wdata, mem_out,
        input gnt, rvalid, rdata, mem_select, mem_addr, sp_addr, write_data, rd_en, wr_en, bram_or_spram
`ifdef MEM_ARB_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register carrying {valid, owner} for each issued read
// Ports: clk, reset (sync, active-high, flushes), push_valid/push_tag in, out_valid/out_tag after RD_LAT cycles.
module rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push_valid,
    input  logic push_tag,
    output logic out_valid,
    output logic out_tag
);
    logic [RD_LAT-1:0] v, t;
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            t <= '0;
        end else begin
            v[0] <= push_valid;
            t[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                v[i] <= v[i-1];
                t[i] <= t[i-1];
            end
        end
    end
    assign out_valid = v[RD_LAT-1];
    assign out_tag = t[RD_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one BRAM/SPRAM port between host (r0) and fabric (r1) with burst lock
// Ports: clk, reset (sync, active-high), bus (mem_port_arbiter_if.slave: requester and memory signals).
// Optional MEM_ARB_TIMEOUT_EN adds TIMEOUT_CYCLES and bus.timeout: breaks a lock held with no traffic.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_SELECT_BITS = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1023
`endif
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    state_t state, state_n;
    logic owner, owner_n, ptr, ptr_n, other, issue, rel, expire, pv, pt;
    logic [ADDR_W-1:0] a;
    assign other = ~owner;
    assign a = owner ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
    // Outputs are held at zero while reset is asserted so an in-flight read never reports.
    assign issue = !reset && state == OWN && bus.req[owner];
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // Fires on the TIMEOUT_CYCLES-th consecutive owned cycle without a request.
    assign expire = state == OWN && !bus.req[owner] && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset || state != OWN || bus.req[owner] || expire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
    assign bus.timeout = (expire && !reset) ? onehot(owner) : 2'b00;
`else
    assign expire = 1'b0;
`endif
    // A single-beat owner yields to a waiting peer after every access.
    assign rel = state == OWN && (expire || (!bus.lock[owner] && (!bus.req[owner] || bus.req[other])));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= REQ_HOST;
            ptr <= REQ_HOST;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr <= ptr_n;
        end
    end
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n = ptr;
        if (state == IDLE && |bus.req) begin
            state_n = OWN;
            owner_n = &bus.req ? ptr : bus.req[REQ_FABRIC];
        end else if (rel) begin
            state_n = IDLE;
            ptr_n = other;
        end
    end
    assign bus.gnt = (state == OWN && !reset) ? onehot(owner) : 2'b00;
    assign bus.rd_en = issue && !bus.wr[owner];
    assign bus.wr_en = issue && bus.wr[owner];
    assign bus.bram_or_spram = issue && bus.spram[owner];
    assign bus.mem_addr = issue ? a[7:0] : '0;
    assign bus.sp_addr = issue ? a[13:0] : '0;
    assign bus.mem_select = !issue ? '0 : owner ? bus.sel[2*MEM_SELECT_BITS-1:MEM_SELECT_BITS] : bus.sel[MEM_SELECT_BITS-1:0];
    assign bus.write_data = !issue ? '0 : owner ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
    // Tags travel with the read so responses follow the issuer even after the grant moves on.
    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk(clk),
        .reset(reset),
        .push_valid(bus.rd_en),
        .push_tag(owner),
        .out_valid(pv),
        .out_tag(pt)
    );
    assign bus.rvalid = (pv && !reset) ? onehot(pt) : 2'b00;
    assign bus.rdata = (pv && !reset) ? bus.mem_out : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int MSB = 4, AW = 14, DW = 16, RD_LAT = 1;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`endif
    typedef struct {
        logic rst;
        logic [1:0] req, lock, wr;
        logic [7:0] a0, a1;
        logic [1:0] gnt;
        logic rd, we;
        logic [7:0] ma;
        logic [1:0] rv;
    } vec_t;
    typedef struct {
        int due;
        int tag;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    vec_t tbl[24];
    rd_t q[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.MEM_SELECT_BITS(MSB), .ADDR_W(AW), .DATA_W(DW)) bus();

    mem_port_arbiter #(
        .MEM_SELECT_BITS(MSB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] rq, lk, w, input logic [7:0] a0, a1);
        reset = r;
        bus.req = rq;
        bus.lock = lk;
        bus.wr = w;
        bus.spram = 2'b00;
        bus.sel = 8'h21;
        bus.addr = {6'h05, a1, 6'h0A, a0};
        bus.wdata = {16'hB0B0, 16'hA0A0};
        bus.mem_out = 16'hBEEF;
    endtask

    task automatic check_row(input string n, input logic [1:0] g, input logic rd, we, input logic [7:0] ma, input logic [1:0] rv);
        chk({n, ".gnt"}, 128'(bus.gnt), 128'(g));
        chk({n, ".rd_en"}, 128'(bus.rd_en), 128'(rd));
        chk({n, ".wr_en"}, 128'(bus.wr_en), 128'(we));
        chk({n, ".mem_addr"}, 128'(bus.mem_addr), 128'(ma));
        chk({n, ".rvalid"}, 128'(bus.rvalid), 128'(rv));
        chk({n, ".rdata"}, 128'(bus.rdata), 128'((rv != 2'b00) ? 16'hBEEF : 16'h0000));
    endtask

    initial begin
        logic rst, o, iss, rel, e_rd, e_wr, e_bos;
        logic [1:0] rq, lk, w, sp, e_gnt, e_rv, e_to;
        logic [27:0] ad;
        logic [13:0] sa, e_sp;
        logic [7:0] sl, e_ma;
        logic [3:0] e_sel;
        logic [31:0] wd;
        logic [15:0] mo, e_wd, e_rdata;
        int owner, ptr, idle;

        tbl = '{
            '{1'b0, 2'b01, 2'b00, 2'b00, 8'h12, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b01, 2'b00, 2'b00, 8'h12, 8'h00, 2'b01, 1'b1, 1'b0, 8'h12, 2'b00},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h12, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b11, 2'b00, 2'b00, 8'h21, 8'h31, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b11, 2'b00, 2'b00, 8'h21, 8'h31, 2'b01, 1'b1, 1'b0, 8'h21, 2'b00},
            '{1'b0, 2'b10, 2'b00, 2'b00, 8'h21, 8'h31, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01},
            '{1'b0, 2'b10, 2'b00, 2'b00, 8'h21, 8'h31, 2'b10, 1'b1, 1'b0, 8'h31, 2'b00},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h21, 8'h31, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b11, 2'b01, 2'b11, 8'h40, 8'h55, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b11, 2'b01, 2'b01, 8'h40, 8'h55, 2'b01, 1'b0, 1'b1, 8'h40, 2'b00},
            '{1'b0, 2'b11, 2'b01, 2'b01, 8'h41, 8'h55, 2'b01, 1'b0, 1'b1, 8'h41, 2'b00},
            '{1'b0, 2'b11, 2'b01, 2'b01, 8'h42, 8'h55, 2'b01, 1'b0, 1'b1, 8'h42, 2'b00},
            '{1'b0, 2'b11, 2'b00, 2'b01, 8'h43, 8'h55, 2'b01, 1'b0, 1'b1, 8'h43, 2'b00},
            '{1'b0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h55, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b10, 2'b00, 2'b00, 8'h00, 8'h55, 2'b10, 1'b1, 1'b0, 8'h55, 2'b00},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h55, 2'b10, 1'b0, 1'b0, 8'h00, 2'b10},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b01, 2'b00, 2'b00, 8'h66, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b01, 2'b00, 2'b00, 8'h66, 8'h00, 2'b01, 1'b1, 1'b0, 8'h66, 2'b00},
            '{1'b1, 2'b01, 2'b00, 2'b00, 8'h66, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00},
            '{1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00}
        };

        drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        check_row("reset", 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].wr, tbl[i].a0, tbl[i].a1);
            #1;
            check_row($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].rd, tbl[i].we, tbl[i].ma, tbl[i].rv);
        end

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b0, 2'b11, 2'b00, 2'b00, 8'h0C, 8'h0D);
            #1;
            check_row($sformatf("alt%0d", k),
                      (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b01 : 2'b10),
                      k % 2 == 1, 1'b0,
                      (k % 2 == 0) ? 8'h00 : ((k % 4 == 1) ? 8'h0C : 8'h0D),
                      (k % 2 == 1 || k == 0) ? 2'b00 : ((k % 4 == 2) ? 2'b01 : 2'b10));
        end
        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
        #1;
        check_row("drain", 2'b00, 1'b0, 1'b0, 8'h00, 2'b10);

`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge clk);
        drive(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h77);
        #1;
        check_row("to_req", 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
        @(negedge clk);
        drive(1'b0, 2'b10, 2'b10, 2'b00, 8'h00, 8'h77);
        #1;
        check_row("to_rd", 2'b10, 1'b1, 1'b0, 8'h77, 2'b00);
        for (int j = 1; j <= TO; j++) begin
            @(negedge clk);
            drive(1'b0, 2'b01, 2'b10, 2'b00, 8'h00, 8'h00);
            #1;
            check_row($sformatf("to_idle%0d", j), 2'b10, 1'b0, 1'b0, 8'h00, (j == 1) ? 2'b10 : 2'b00);
            chk($sformatf("to_idle%0d.timeout", j), 128'(bus.timeout), 128'((j == TO) ? 2'b10 : 2'b00));
        end
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
        #1;
        check_row("to_rel", 2'b00, 1'b0, 1'b0, 8'h00, 2'b00);
        chk("to_rel.timeout", 128'(bus.timeout), 128'(2'b00));
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00);
        #1;
        check_row("to_host", 2'b01, 1'b1, 1'b0, 8'h00, 2'b00);
`endif

        owner = -1;
        ptr = 0;
        idle = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = (c == 0) || ($urandom_range(63) == 0);
            rq = 2'($urandom_range(3));
            lk = {$urandom_range(3) == 0, $urandom_range(3) == 0};
            w = 2'($urandom_range(3));
            sp = 2'($urandom_range(3));
            sl = 8'($urandom);
            ad = 28'($urandom);
            wd = $urandom;
            mo = 16'($urandom);
            reset = rst;
            bus.req = rq;
            bus.lock = lk;
            bus.wr = w;
            bus.spram = sp;
            bus.sel = sl;
            bus.addr = ad;
            bus.wdata = wd;
            bus.mem_out = mo;
            #1;
            o = 1'b0;
            iss = 1'b0;
            e_gnt = 2'b00;
            e_rv = 2'b00;
            e_to = 2'b00;
            e_rd = 1'b0;
            e_wr = 1'b0;
            e_bos = 1'b0;
            e_ma = 8'h00;
            e_sp = 14'h0;
            e_sel = 4'h0;
            e_wd = 16'h0;
            e_rdata = 16'h0;
            if (!rst && owner >= 0) begin
                o = owner[0];
                e_gnt = o ? 2'b10 : 2'b01;
                iss = rq[o];
                if (iss) begin
                    sa = o ? ad[27:14] : ad[13:0];
                    e_rd = !w[o];
                    e_wr = w[o];
                    e_bos = sp[o];
                    e_ma = sa[7:0];
                    e_sp = sa;
                    e_sel = o ? sl[7:4] : sl[3:0];
                    e_wd = o ? wd[31:16] : wd[15:0];
                end
`ifdef MEM_ARB_TIMEOUT_EN
                e_to = (!iss && idle == TO - 1) ? e_gnt : 2'b00;
`endif
            end
            if (!rst && q.size() > 0 && q[0].due == c) begin
                e_rv = (q[0].tag == 1) ? 2'b10 : 2'b01;
                e_rdata = mo;
            end
            chk($sformatf("rand%0d", c),
                128'({bus.gnt, bus.rvalid, bus.rdata, bus.rd_en, bus.wr_en, bus.bram_or_spram,
                      bus.mem_addr, bus.sp_addr, bus.mem_select, bus.write_data}),
                128'({e_gnt, e_rv, e_rdata, e_rd, e_wr, e_bos, e_ma, e_sp, e_sel, e_wd}));
`ifdef MEM_ARB_TIMEOUT_EN
            chk($sformatf("rand%0d.timeout", c), 128'(bus.timeout), 128'(e_to));
`endif
            if (q.size() > 0 && q[0].due == c) void'(q.pop_front());
            if (rst) begin
                owner = -1;
                ptr = 0;
                idle = 0;
                q.delete();
            end else if (owner < 0) begin
                if (rq != 2'b00) owner = (rq == 2'b11) ? ptr : ((rq == 2'b10) ? 1 : 0);
            end else begin
                if (e_rd) q.push_back('{c + RD_LAT, owner});
                rel = !lk[o] && (!rq[o] || rq[!o]);
                if (e_to != 2'b00) rel = 1'b1;
                idle = iss ? 0 : idle + 1;
                if (rel) begin
                    ptr = 1 - owner;
                    owner = -1;
                    idle = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
